rx_frame_assembler: RTL and testbench
=====================================

Name: rx_frame_assembler

Overview:
- Sits directly downstream of frame_decode and consumes its soc/eoc/data/error pulses.
- Assembles the bytes of one PCD frame into a local buffer and runs CRC_A over the complete bytes.
- At EOC it presents a frame summary (length, partial-bit count, CRC and error flags), held until the protocol layer acknowledges it.
- The protocol layer reads the bytes through a synchronous read port.

Parameters:
MAX_BYTES, 32, buffer depth in bytes (>= 3)
LEN_W, $clog2(MAX_BYTES+1), width of the length field (derived, not overridable)

Ports:
clk  input  1  13.56MHz recovered carrier clock; stops during pauses
rst_n  input  1  asynchronous active-low reset
fd_soc  input  1  start-of-comms pulse
fd_eoc  input  1  end-of-comms pulse
fd_data  input  8  data byte, LSB first received
fd_data_bits  input  3  valid bits in fd_data; 0 means 8
fd_data_valid  input  1  fd_data/fd_data_bits valid this cycle
fd_sequence_error  input  1  sequence error pulse
fd_parity_error  input  1  parity error pulse
frame_valid  output  1  summary valid; held until frame_ack
frame_ack  input  1  consumer releases frame and buffer
frame_len  output  LEN_W  stored bytes, including a trailing partial byte
frame_last_bits  output  3  valid bits of last byte; 0 means full byte
frame_crc_ok  output  1  CRC_A residue check passed
frame_parity_error  output  1  parity error seen in frame
frame_sequence_error  output  1  sequence error seen in frame
frame_overflow  output  1  more than MAX_BYTES bytes received
rd_addr  input  LEN_W  byte read address
rd_data  output  8  buffer[rd_addr], registered, 1-cycle latency
overrun  output  1  one-cycle pulse: SOC arrived while a frame was pending

Behaviour:
- Reset: state IDLE; all outputs 0; rd_data 0; internal count 0; CRC register 0x6363.
- State IDLE:
  - fd_soc -> RECEIVING; clear count, error flags and last_bits; CRC register := 0x6363.
  - fd_eoc and fd_data_valid are ignored.
- State RECEIVING, on fd_data_valid:
  - If count < MAX_BYTES: write the byte to buffer[count] and increment count.
  - Partial byte (fd_data_bits != 0): store masked, bits >= fd_data_bits forced to 0; record last_bits := fd_data_bits.
  - Full byte only: CRC_A update over all 8 bits in one cycle; reflected poly 0x8408, LSB first, no final XOR.
  - Partial bytes never enter the CRC.
  - If count == MAX_BYTES: drop the byte and set the overflow flag.
- State RECEIVING, other events:
  - fd_parity_error / fd_sequence_error: set the matching sticky flag.
  - fd_soc: restart the frame exactly as from IDLE, discarding the current frame.
- Same-cycle ordering in one fd cycle: fd_data_valid and fd_eoc may coincide (partial byte at EOC); so may the error pulses with fd_eoc. Apply the data and the error flags first, then EOC.
- EOC in RECEIVING -> PENDING. On the next cycle:
  - frame_valid = 1; the summary is registered from the updated values.
  - frame_crc_ok = (CRC register == 0x0000) && (frame_len >= 3) && (last_bits == 0) && no parity/sequence error && !overflow.
- State PENDING:
  - All summary outputs and the buffer contents are frozen.
  - frame_ack -> IDLE next cycle; frame_valid deasserts at that edge.
  - fd_soc (with or without same-cycle frame_ack) -> overrun pulse on the next cycle. The new frame is ignored until IDLE, i.e. all fd activity is dropped until the next fd_soc seen in IDLE.
- Zero-byte frame (SOC then EOC, sequence_error set by upstream): reported with frame_len 0 and frame_crc_ok 0.
- Read port:
  - rd_data <= buffer[rd_addr] every cycle, in every state.
  - rd_addr >= MAX_BYTES returns 0.
  - Reads during RECEIVING return stale or in-progress data; this is permitted but undefined.
- frame_ack outside PENDING: ignored.
- Reset mid-frame: immediate return to IDLE with all outputs 0. Buffer contents are not cleared (no reset on the RAM array).
- clk may stop at any point; no timeouts.

Decomposition:
- ISO14443A_pkg gets:
  - CRC_A_INIT = 16'h6363
  - CRC_A_POLY_REFLECTED = 16'h8408
  - CRC_A_RESIDUE = 16'h0000
  - function crc_a_byte(crc, byte) returning the next CRC
  - typedef enum RxFrameState {IDLE, RECEIVING, PENDING}
- One sub-module, crc_a: registered CRC with init/enable/data inputs, reusable later by the TX path.
- The buffer is an inferred array inside rx_frame_assembler.

Test Plan:
- REQA: SOC, partial byte 0x26 with data_bits=7 + EOC same cycle -> frame_len=1, last_bits=7, rd_data[0]=0x26, crc_ok=0, no errors.
- READ frame: bytes 0x30 0x00 0x02 0xA8 -> frame_len=4, last_bits=0, crc_ok=1. Corrupt the last byte to 0xA9 -> crc_ok=0.
- Parity error after byte 0x93 then EOC -> frame_parity_error=1, frame_len=1, crc_ok=0.
- MAX_BYTES=4, six full bytes -> frame_len=4, frame_overflow=1, buffer holds the first four bytes.
- Frame pending, no ack, second SOC + bytes + EOC -> overrun pulse, first summary unchanged. Ack, then a third frame -> received normally.
- SOC mid-frame after 2 bytes, then 0x26 partial/7 + EOC -> frame_len=1 reflecting only the new frame. Assert rst_n low mid-frame -> all outputs 0, state IDLE.

Source files
------------

// File: rtl/ISO14443A_pkg.sv
// ISO14443A_pkg: shared ISO/IEC 14443-A definitions for the RX/TX paths.
//   CRC_A constants, a single-byte CRC_A update function and the
//   receive-frame FSM state type.
package ISO14443A_pkg;

    localparam logic [15:0] CRC_A_INIT           = 16'h6363;
    localparam logic [15:0] CRC_A_POLY_REFLECTED = 16'h8408;
    localparam logic [15:0] CRC_A_RESIDUE        = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        RECEIVING,
        PENDING
    } RxFrameState;

    // One full byte, LSB first, reflected polynomial, no final XOR.
    function automatic logic [15:0] crc_a_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_A_POLY_REFLECTED) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_a.sv
// crc_a: registered CRC_A accumulator.
//   clk, rst_n : clock, async active-low reset (register resets to CRC_A_INIT)
//   init       : load CRC_A_INIT (wins over en)
//   en, data   : fold one full byte into the CRC
//   crc        : current CRC register
module crc_a
    import ISO14443A_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_A_INIT;
        end else if (init) begin
            crc <= CRC_A_INIT;
        end else if (en) begin
            crc <= crc_a_byte(crc, data);
        end
    end

endmodule

// File: rtl/rx_frame_assembler.sv
// rx_frame_assembler: collects frame_decode bytes of one PCD frame into a
// local buffer, runs CRC_A over full bytes and presents a frame summary at
// EOC, held until frame_ack.
//   fd_*           : soc/eoc/data/error pulses from frame_decode
//   frame_*        : summary, valid while frame_valid (otherwise 0)
//   rd_addr/rd_data: synchronous buffer read, 1-cycle latency
//   overrun        : pulse when SOC arrives while a frame is pending
module rx_frame_assembler
    import ISO14443A_pkg::*;
#(
    parameter  int MAX_BYTES = 32,
    localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fd_soc,
    input  logic             fd_eoc,
    input  logic [7:0]       fd_data,
    input  logic [2:0]       fd_data_bits,
    input  logic             fd_data_valid,
    input  logic             fd_sequence_error,
    input  logic             fd_parity_error,
    output logic             frame_valid,
    input  logic             frame_ack,
    output logic [LEN_W-1:0] frame_len,
    output logic [2:0]       frame_last_bits,
    output logic             frame_crc_ok,
    output logic             frame_parity_error,
    output logic             frame_sequence_error,
    output logic             frame_overflow,
    input  logic [LEN_W-1:0] rd_addr,
    output logic [7:0]       rd_data,
    output logic             overrun
);

    localparam int              AW      = $clog2(MAX_BYTES);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(3);

    RxFrameState state, state_nxt;

    logic [LEN_W-1:0] count;
    logic [2:0]       last_bits;
    logic             par_err, seq_err, ovf;
    logic [15:0]      crc;
    logic [7:0]       buf_mem [MAX_BYTES];

    // SOC restarts the frame from IDLE or RECEIVING; in PENDING it is an overrun.
    logic       restart, rx_data, store, pend;
    logic [7:0] mask;

    assign restart = (state != PENDING) && fd_soc;
    assign rx_data = (state == RECEIVING) && !fd_soc && fd_data_valid;
    assign store   = rx_data && (count < MAX_LEN);
    assign mask    = (fd_data_bits == 3'd0) ? 8'hFF : 8'((9'h1 << fd_data_bits) - 9'h1);
    assign pend    = (state == PENDING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (fd_soc) state_nxt = RECEIVING;
            RECEIVING: if (fd_soc) state_nxt = RECEIVING;
                       else if (fd_eoc) state_nxt = PENDING;
            PENDING:   if (frame_ack) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Partial bytes never enter the CRC.
    crc_a u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .init  (restart),
        .en    (store && (fd_data_bits == 3'd0)),
        .data  (fd_data),
        .crc   (crc)
    );

    // Data and error pulses land in the same edge as EOC, so the summary
    // seen in PENDING already includes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            last_bits <= 3'd0;
            par_err   <= 1'b0;
            seq_err   <= 1'b0;
            ovf       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= pend && fd_soc;
            if (restart) begin
                count     <= '0;
                last_bits <= 3'd0;
                par_err   <= 1'b0;
                seq_err   <= 1'b0;
                ovf       <= 1'b0;
            end else if (state == RECEIVING) begin
                if (store) begin
                    count     <= count + 1'b1;
                    last_bits <= fd_data_bits;
                end
                if (rx_data && !store) ovf     <= 1'b1;
                if (fd_parity_error)   par_err <= 1'b1;
                if (fd_sequence_error) seq_err <= 1'b1;
            end
        end
    end

    // Buffer RAM: no reset so it maps onto memory.
    always_ff @(posedge clk) begin
        if (store) buf_mem[count[AW-1:0]] <= fd_data & mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                rd_data <= 8'h00;
        else if (rd_addr < MAX_LEN) rd_data <= buf_mem[rd_addr[AW-1:0]];
        else                       rd_data <= 8'h00;
    end

    // Internal state is frozen in PENDING, so gating it gives a held summary.
    assign frame_valid          = pend;
    assign frame_len            = pend ? count : '0;
    assign frame_last_bits      = pend ? last_bits : 3'd0;
    assign frame_parity_error   = pend && par_err;
    assign frame_sequence_error = pend && seq_err;
    assign frame_overflow       = pend && ovf;
    assign frame_crc_ok         = pend && (crc == CRC_A_RESIDUE) && (count >= MIN_LEN)
                                  && (last_bits == 3'd0) && !par_err && !seq_err && !ovf;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// tb_rx_frame_assembler: directed + randomized frames against a queue-based
// reference model of the frame summary and buffer contents (MAX_BYTES = 4).
module tb_rx_frame_assembler;

    localparam int MAXB = 4;
    localparam int LW   = $clog2(MAXB + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fd_soc = 0, fd_eoc = 0, fd_data_valid = 0;
    logic          fd_sequence_error = 0, fd_parity_error = 0;
    logic [7:0]    fd_data = 8'h00;
    logic [2:0]    fd_data_bits = 3'd0;
    logic          frame_ack = 0;
    logic          frame_valid, frame_crc_ok, frame_parity_error;
    logic          frame_sequence_error, frame_overflow, overrun;
    logic [LW-1:0] frame_len;
    logic [2:0]    frame_last_bits;
    logic [LW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;

    rx_frame_assembler #(.MAX_BYTES(MAXB)) dut (
        .clk(clk), .rst_n(rst_n),
        .fd_soc(fd_soc), .fd_eoc(fd_eoc), .fd_data(fd_data),
        .fd_data_bits(fd_data_bits), .fd_data_valid(fd_data_valid),
        .fd_sequence_error(fd_sequence_error), .fd_parity_error(fd_parity_error),
        .frame_valid(frame_valid), .frame_ack(frame_ack),
        .frame_len(frame_len), .frame_last_bits(frame_last_bits),
        .frame_crc_ok(frame_crc_ok), .frame_parity_error(frame_parity_error),
        .frame_sequence_error(frame_sequence_error), .frame_overflow(frame_overflow),
        .rd_addr(rd_addr), .rd_data(rd_data), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // frame under test: bytes as sent, with their valid-bit counts
    logic [7:0] fb[$];
    logic [2:0] fbits[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial CRC_A reference.
    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fbk;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fbk = r[0] ^ d[i];
            r   = r >> 1;
            if (fbk) r = r ^ 16'h8408;
        end
        return r;
    endfunction

    task automatic soc_pulse();
        fd_soc = 1; tick(); fd_soc = 0;
    endtask

    task automatic drive(input logic dv, input logic [7:0] d, input logic [2:0] bits,
                         input logic eoc, input logic par, input logic seq);
        fd_data_valid = dv; fd_data = d; fd_data_bits = bits;
        fd_eoc = eoc; fd_parity_error = par; fd_sequence_error = seq;
        tick();
        fd_data_valid = 0; fd_eoc = 0; fd_parity_error = 0; fd_sequence_error = 0;
    endtask

    // together: EOC (and errors) ride on the last data cycle
    task automatic send_frame(input logic par, input logic seq, input logic together);
        int n;
        n = fb.size();
        soc_pulse();
        for (int i = 0; i < n; i++) begin
            if (i == n - 1 && together) drive(1, fb[i], fbits[i], 1, par, seq);
            else                        drive(1, fb[i], fbits[i], 0, 0, 0);
        end
        if (!together || n == 0) drive(0, 8'h00, 3'd0, 1, par, seq);
    endtask

    task automatic expect_frame(input string tag, input logic par, input logic seq);
        int          n, len;
        logic [15:0] c;
        logic [2:0]  lb;
        logic        ovf, ok;
        logic [7:0]  m;
        n   = fb.size();
        len = (n > MAXB) ? MAXB : n;
        ovf = (n > MAXB);
        lb  = (len > 0) ? fbits[len-1] : 3'd0;
        c   = 16'h6363;
        for (int i = 0; i < len; i++) if (fbits[i] == 0) c = crc_ref(c, fb[i]);
        ok = (c == 16'h0000) && (len >= 3) && (lb == 0) && !par && !seq && !ovf;
        chk({tag, ".valid"}, frame_valid, 1);
        chk({tag, ".len"},   frame_len, len);
        chk({tag, ".lbits"}, frame_last_bits, lb);
        chk({tag, ".crc"},   frame_crc_ok, ok);
        chk({tag, ".par"},   frame_parity_error, par);
        chk({tag, ".seq"},   frame_sequence_error, seq);
        chk({tag, ".ovf"},   frame_overflow, ovf);
        for (int i = 0; i < len; i++) begin
            m = (fbits[i] == 0) ? 8'hFF : ~(8'hFF << fbits[i]);
            rd_addr = LW'(i); tick();
            chk({tag, ".rd"}, rd_data, fb[i] & m);
        end
    endtask

    task automatic ack();
        frame_ack = 1; tick(); frame_ack = 0;
        chk("ack.valid", frame_valid, 0);
    endtask

    task automatic set_frame(input logic [7:0] b[$], input logic [2:0] last_bits);
        fb = b; fbits.delete();
        foreach (b[i]) fbits.push_back(3'd0);
        if (fb.size() > 0) fbits[fb.size()-1] = last_bits;
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [15:0] c;
        int          mode, n;
        logic        par, seq, tog;

        #12;
        chk("rst.valid", frame_valid, 0);
        chk("rst.len", frame_len, 0);
        chk("rst.rd", rd_data, 0);
        chk("rst.ovr", overrun, 0);
        rst_n = 1;
        tick();

        // REQA: 7-bit partial byte with EOC in the same cycle
        q = '{8'h26}; set_frame(q, 3'd7);
        send_frame(0, 0, 1); expect_frame("reqa", 0, 0); ack();

        // READ block 0 with valid CRC, then corrupted
        q = '{8'h30, 8'h00, 8'h02, 8'hA8}; set_frame(q, 3'd0);
        send_frame(0, 0, 0); expect_frame("read", 0, 0);
        chk("read.ok", frame_crc_ok, 1);
        rd_addr = LW'(MAXB); tick(); chk("rd.oob", rd_data, 0);
        ack();
        q = '{8'h30, 8'h00, 8'h02, 8'hA9}; set_frame(q, 3'd0);
        send_frame(0, 0, 0); expect_frame("readbad", 0, 0); ack();

        // parity error then EOC
        q = '{8'h93}; set_frame(q, 3'd0);
        soc_pulse(); drive(1, 8'h93, 3'd0, 0, 0, 0);
        drive(0, 8'h00, 3'd0, 0, 1, 0); drive(0, 8'h00, 3'd0, 1, 0, 0);
        expect_frame("par", 1, 0); ack();

        // overflow: six bytes into a four-byte buffer
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}; set_frame(q, 3'd0);
        send_frame(0, 0, 0); expect_frame("ovf", 0, 0); ack();

        // overrun: pending frame, second frame must be dropped
        q = '{8'h30, 8'h00, 8'h02, 8'hA8}; set_frame(q, 3'd0);
        send_frame(0, 0, 0);
        soc_pulse(); chk("ovr.pulse", overrun, 1);
        drive(1, 8'hEE, 3'd0, 0, 1, 1); chk("ovr.clear", overrun, 0);
        drive(1, 8'hDD, 3'd0, 1, 0, 0);
        expect_frame("ovr.hold", 0, 0); ack();
        q = '{8'h50, 8'h00, 8'h57}; set_frame(q, 3'd0);
        send_frame(0, 0, 0); expect_frame("third", 0, 0); ack();

        // SOC mid-frame restarts
        q = '{8'h26}; set_frame(q, 3'd7);
        soc_pulse(); drive(1, 8'hAA, 3'd0, 0, 0, 0); drive(1, 8'hBB, 3'd0, 0, 1, 0);
        send_frame(0, 0, 1); expect_frame("restart", 0, 0); ack();

        // reset mid-frame
        soc_pulse(); drive(1, 8'h12, 3'd0, 0, 0, 0);
        #2 rst_n = 0; #1;
        chk("rstmid.valid", frame_valid, 0);
        chk("rstmid.len", frame_len, 0);
        chk("rstmid.rd", rd_data, 0);
        #4 rst_n = 1; tick();
        drive(1, 8'h34, 3'd0, 1, 0, 0);
        chk("rstmid.idle", frame_valid, 0);

        // randomized frames
        for (int k = 0; k < 40; k++) begin
            mode = $urandom_range(0, 2);
            q.delete();
            if (mode == 0) begin
                n = $urandom_range(1, 2);
                c = 16'h6363;
                for (int i = 0; i < n; i++) begin
                    q.push_back(8'($urandom));
                    c = crc_ref(c, q[i]);
                end
                q.push_back(c[7:0]); q.push_back(c[15:8]);
                set_frame(q, 3'd0);
            end else begin
                n = $urandom_range(0, 6);
                for (int i = 0; i < n; i++) q.push_back(8'($urandom));
                set_frame(q, (mode == 2) ? 3'($urandom_range(1, 7)) : 3'd0);
            end
            par = ($urandom_range(0, 7) == 0);
            seq = ($urandom_range(0, 7) == 0);
            tog = 1'($urandom);
            send_frame(par, seq, tog);
            expect_frame("rnd", par, seq);
            ack();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
